// File: rtl/logic_universal_pkg.sv
// Shared types and constants for the logic_universal serializer/deserializer family.
// The deserializer FSM state and lane geometry live here.
package logic_universal_pkg;

  typedef enum logic {FILL, HOLD} deser_state_t;

  localparam int DESER_LANES = 8;
  localparam int DESER_SEL_W = 3;

endpackage

// File: rtl/demux_1_to_8_deser_lane_decoder.sv
// Combinational 3-to-8 one-hot decoder of the lane select, gated by the accept
// strobe, producing one write enable per output lane.
module lane_decoder_3_to_8
  import logic_universal_pkg::*;
(
  input  logic [DESER_SEL_W-1:0] sel,
  input  logic                   en,
  output logic [DESER_LANES-1:0] lane_en
);

  always_comb begin
    lane_en = '0;
    if (en) begin
      lane_en[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_1_to_8_deser.sv
// 1-to-8 deserializer: gathers consecutive input words into lanes a..h and
// presents each full (or flushed partial) group with a valid/ready handshake.
module demux_1_to_8_deser
  import logic_universal_pkg::*;
#(
  parameter int INPUT_BIT_LENGTH = 1
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [((INPUT_BIT_LENGTH > 0) ? INPUT_BIT_LENGTH-1 : 0):0] in_data,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic                                                   flush,
  output logic [((INPUT_BIT_LENGTH > 0) ? INPUT_BIT_LENGTH-1 : 0):0] a,
  output logic [((INPUT_BIT_LENGTH > 0) ? INPUT_BIT_LENGTH-1 : 0):0] b,
  output logic [((INPUT_BIT_LENGTH > 0) ? INPUT_BIT_LENGTH-1 : 0):0] c,
  output logic [((INPUT_BIT_LENGTH > 0) ? INPUT_BIT_LENGTH-1 : 0):0] d,
  output logic [((INPUT_BIT_LENGTH > 0) ? INPUT_BIT_LENGTH-1 : 0):0] e,
  output logic [((INPUT_BIT_LENGTH > 0) ? INPUT_BIT_LENGTH-1 : 0):0] f,
  output logic [((INPUT_BIT_LENGTH > 0) ? INPUT_BIT_LENGTH-1 : 0):0] g,
  output logic [((INPUT_BIT_LENGTH > 0) ? INPUT_BIT_LENGTH-1 : 0):0] h,
  output logic [3:0]                                             out_count,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [DESER_SEL_W-1:0]                                 sel
);

  localparam int W = (INPUT_BIT_LENGTH > 0) ? INPUT_BIT_LENGTH : 1;

  deser_state_t                 state;
  deser_state_t                 next_state;
  logic [DESER_SEL_W-1:0]       next_sel;
  logic [3:0]                   next_count;
  logic                         accept;
  logic                         emit;
  logic [DESER_LANES-1:0]       lane_en;
  logic [W-1:0]                 lanes [DESER_LANES];

  // In HOLD the block can only take a word when the held group leaves in the same cycle.
  assign in_ready  = (state == FILL) ? 1'b1 : out_ready;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  lane_decoder_3_to_8 u_lane_decoder (
    .sel     (sel),
    .en      (accept),
    .lane_en (lane_en)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      sel       <= '0;
      out_count <= '0;
    end else begin
      state     <= next_state;
      sel       <= next_sel;
      out_count <= next_count;
    end
  end

  always_comb begin
    next_state = state;
    next_sel   = sel;
    next_count = out_count;
    case (state)
      FILL: begin
        if (accept) begin
          if (sel == 3'd7) begin
            next_count = 4'd8;
            next_sel   = '0;
            next_state = HOLD;
          end else if (flush) begin
            next_count = {1'b0, sel} + 4'd1;
            next_sel   = '0;
            next_state = HOLD;
          end else begin
            next_sel = sel + 3'd1;
          end
        end else if (flush && (sel != '0)) begin
          next_count = {1'b0, sel};
          next_sel   = '0;
          next_state = HOLD;
        end
      end
      HOLD: begin
        // sel is always 0 here, so a word accepted alongside the emit lands in lane a.
        if (emit) begin
          if (accept && flush) begin
            next_count = 4'd1;
            next_sel   = '0;
            next_state = HOLD;
          end else if (accept) begin
            next_sel   = 3'd1;
            next_state = FILL;
          end else begin
            next_sel   = '0;
            next_state = FILL;
          end
        end
      end
      default: begin
        next_state = FILL;
        next_sel   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DESER_LANES; i++) begin
        lanes[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DESER_LANES; i++) begin
        if (lane_en[i]) begin
          lanes[i] <= in_data;
        end
      end
    end
  end

  assign a = lanes[0];
  assign b = lanes[1];
  assign c = lanes[2];
  assign d = lanes[3];
  assign e = lanes[4];
  assign f = lanes[5];
  assign g = lanes[6];
  assign h = lanes[7];

endmodule
